alu_result_stage: RTL and testbench
===================================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter WIDTH, default 32: ALU result width.
REQ-002 Parameter DEST_W, default 5: destination register index width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, named `clk` and `rst_n` as elsewhere in the codebase.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  ALU result offered.
REQ-007 in_ready  out  1  stage can accept this cycle.
REQ-008 in_result  in  WIDTH  ALU result.
REQ-009 in_carry / in_sign / in_zero  in  1 each  ALU flags.
REQ-010 in_flag_we  in  1  accepted flags update the flag register.
REQ-011 in_cond  in  3  branch condition code.
REQ-012 in_dest  in  DEST_W  destination register index.
REQ-013 flush  in  1  synchronous discard of buffered entries.
REQ-014 out_valid  out  1  entry available.
REQ-015 out_ready  in  1  consumer takes entry.
REQ-016 out_result  out  WIDTH; out_dest  out  DEST_W; out_taken  out  1  condition outcome of head entry.
REQ-017 flags_q  out  3  architectural {carry, sign, zero}.

Function
REQ-018 The block SHALL be an in-order 2-entry buffer; push = in_valid & in_ready, pop = out_valid & out_ready.
REQ-019 in_ready SHALL equal (count < 2), driven from registered count only, with no combinational path from out_ready.
REQ-020 out_valid SHALL equal (count > 0); out_* SHALL present the oldest entry from registers.
REQ-021 Latency: an entry pushed in cycle N SHALL be visible on out_* in cycle N+1 when the buffer was empty.
REQ-022 Simultaneous push and pop at count 1 SHALL leave count 1, the new entry becoming head in the next cycle.
REQ-023 At count 2, push SHALL be impossible (in_ready 0); pop SHALL reduce count to 1.
REQ-024 Eval flags SHALL be the incoming flags when in_flag_we=1, otherwise flags_q.
REQ-025 out_taken SHALL be stored at push as: 0 always=1; 1 EQ=Z; 2 NE=!Z; 3 CS=C; 4 CC=!C; 5 MI=S; 6 PL=!S; 7 never=0.
REQ-026 On push with in_flag_we=1, flags_q SHALL load {in_carry, in_sign, in_zero} at that edge; otherwise hold.
REQ-027 flush SHALL set count 0 and read/write pointers to 0; flush SHALL override a same-cycle push and pop; flags_q SHALL be unaffected by a pushed-and-flushed entry.
REQ-028 Pointers SHALL wrap modulo 2.

Reset
REQ-029 rst_n low SHALL immediately set count 0, pointers 0, flags_q 0, out_valid 0, in_ready 1, out_result 0, out_dest 0, out_taken 0.
REQ-030 Reset mid-transfer SHALL discard all entries; first push after rst_n rises SHALL be accepted normally.

Structure
REQ-031 Condition-code constants (COND_AL ... COND_NV) and the flag-vector bit order SHALL live in the shared CPU package with the ALU opcode constants.
REQ-032 Condition evaluation SHALL be one combinational sub-module, cond_eval (3-bit flags, 3-bit cond -> taken).

Verification
REQ-033 Push result 0x0000_0005, dest 3, cond EQ, flags {0,0,1}, flag_we=1 -> next cycle out_valid=1, out_result 0x5, out_dest 3, out_taken 1, flags_q 3'b001.
REQ-034 out_ready=0, push three results A, B, C back-to-back -> A and B accepted, in_ready 0 in the third cycle, C stalls; then out_ready=1 -> order A, B, C.
REQ-035 Push flag_we=1 with carry=1; push flag_we=0, cond CS -> second out_taken 1; cond CC -> 0.
REQ-036 count 1, in_valid and out_ready both 1 for 4 cycles -> count stays 1, every value emitted once in order.
REQ-037 count 2, flush with in_valid=1 -> next cycle out_valid 0, in_ready 1, flags_q unchanged.
REQ-038 Assert rst_n low asynchronously mid-cycle with count 2 -> out_valid 0 and flags_q 0 before the next clock edge.

Source files
------------

// File: rtl/alu_result_stage_pkg.sv
// rtl/alu_result_stage_pkg.sv - shared CPU constants: ALU opcodes, condition codes, flag layout
//
// Purpose : constants shared by the ALU and the result stage.
// Ports   : none (package).

package alu_result_stage_pkg;

    // Architectural flag vector layout: {carry, sign, zero}
    localparam int FLAG_W = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_S = 1;
    localparam int FLAG_Z = 0;

    typedef logic [FLAG_W-1:0] flags_t;
    typedef logic [2:0]        cond_t;

    // Branch condition codes
    localparam cond_t COND_AL = 3'd0;
    localparam cond_t COND_EQ = 3'd1;
    localparam cond_t COND_NE = 3'd2;
    localparam cond_t COND_CS = 3'd3;
    localparam cond_t COND_CC = 3'd4;
    localparam cond_t COND_MI = 3'd5;
    localparam cond_t COND_PL = 3'd6;
    localparam cond_t COND_NV = 3'd7;

    // ALU opcodes
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_SLT  = 4'h8;
    localparam logic [3:0] ALU_PASS = 4'h9;

endpackage

// File: rtl/alu_result_stage_cond_eval.sv
// rtl/alu_result_stage_cond_eval.sv - combinational branch condition evaluator
//
// Purpose : maps a condition code and a flag vector to a taken bit.
// Ports   : flags  in  3  {carry, sign, zero}
//           cond   in  3  condition code
//           taken  out 1  condition outcome

module cond_eval
    import alu_result_stage_pkg::*;
(
    input  logic [FLAG_W-1:0] flags,
    input  logic [2:0]        cond,
    output logic              taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_AL: taken = 1'b1;
            COND_EQ: taken = flags[FLAG_Z];
            COND_NE: taken = ~flags[FLAG_Z];
            COND_CS: taken = flags[FLAG_C];
            COND_CC: taken = ~flags[FLAG_C];
            COND_MI: taken = flags[FLAG_S];
            COND_PL: taken = ~flags[FLAG_S];
            COND_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - two-entry in-order ALU result buffer with flag register
//
// Purpose : buffers ALU results, evaluates branch condition at push time and
//           maintains the architectural flag register.
// Ports   : clk, rst_n                      clock, async active-low reset
//           in_valid/in_ready               input handshake
//           in_result, in_dest              result and destination index
//           in_carry/in_sign/in_zero        ALU flags
//           in_flag_we                      flags of accepted entry update flags_q
//           in_cond                         branch condition code
//           flush                           synchronous discard of buffered entries
//           out_valid/out_ready             output handshake
//           out_result, out_dest, out_taken head entry
//           flags_q                         architectural {carry, sign, zero}

module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEST_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_result,
    input  logic              in_carry,
    input  logic              in_sign,
    input  logic              in_zero,
    input  logic              in_flag_we,
    input  logic [2:0]        in_cond,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_result,
    output logic [DEST_W-1:0] out_dest,
    output logic              out_taken,
    output logic [FLAG_W-1:0] flags_q
);

    logic [1:0]        count_q, count_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [FLAG_W-1:0] flags_d;
    logic [WIDTH-1:0]  result_q [2];
    logic [WIDTH-1:0]  result_d [2];
    logic [DEST_W-1:0] dest_q [2];
    logic [DEST_W-1:0] dest_d [2];
    logic [1:0]        taken_q, taken_d;

    logic              push;
    logic              pop;
    logic [FLAG_W-1:0] in_flags;
    logic [FLAG_W-1:0] eval_flags;
    logic              push_taken;

    // Handshake status comes only from registered count, so in_ready has no
    // combinational dependence on out_ready.
    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign in_flags   = {in_carry, in_sign, in_zero};
    // An entry that writes flags is judged against its own flags.
    assign eval_flags = in_flag_we ? in_flags : flags_q;

    cond_eval u_cond_eval (
        .flags (eval_flags),
        .cond  (in_cond),
        .taken (push_taken)
    );

    assign out_result = result_q[rd_ptr_q];
    assign out_dest   = dest_q[rd_ptr_q];
    assign out_taken  = taken_q[rd_ptr_q];

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        flags_d  = flags_q;
        result_d = result_q;
        dest_d   = dest_q;
        taken_d  = taken_q;

        if (flush) begin
            // Flush wins over push and pop; a flushed push never touches flags.
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) begin
                result_d[wr_ptr_q] = in_result;
                dest_d[wr_ptr_q]   = in_dest;
                taken_d[wr_ptr_q]  = push_taken;
                wr_ptr_d           = ~wr_ptr_q;
                if (in_flag_we) begin
                    flags_d = in_flags;
                end
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            flags_q     <= '0;
            result_q[0] <= '0;
            result_q[1] <= '0;
            dest_q[0]   <= '0;
            dest_q[1]   <= '0;
            taken_q     <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            flags_q  <= flags_d;
            result_q <= result_d;
            dest_q   <= dest_d;
            taken_q  <= taken_d;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - self-checking bench for alu_result_stage

module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_result;
    logic        in_carry, in_sign, in_zero, in_flag_we;
    logic [2:0]  in_cond;
    logic [4:0]  in_dest;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_dest;
    logic        out_taken;
    logic [2:0]  flags_q;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(32), .DEST_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result),
        .in_carry(in_carry), .in_sign(in_sign), .in_zero(in_zero),
        .in_flag_we(in_flag_we), .in_cond(in_cond), .in_dest(in_dest),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_dest(out_dest), .out_taken(out_taken),
        .flags_q(flags_q)
    );

    typedef struct {
        logic [2:0] flags;
        logic [2:0] cond;
        logic       exp;
    } cvec_t;

    typedef struct {
        logic [31:0] r;
        logic [4:0]  d;
        logic        t;
    } ent_t;

    cvec_t tbl[16];
    ent_t  mq[$];
    logic [2:0] mflags;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Spec rule: condition outcome from {C,S,Z}
    function automatic logic ref_taken(input logic [2:0] c, input logic [2:0] f);
        logic cy, sg, zr;
        {cy, sg, zr} = f;
        case (c)
            3'd0: return 1'b1;
            3'd1: return zr;
            3'd2: return !zr;
            3'd3: return cy;
            3'd4: return !cy;
            3'd5: return sg;
            3'd6: return !sg;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] d,
                         input logic [2:0] c, input logic [2:0] f, input logic we,
                         input logic ordy, input logic fl);
        in_valid = v; in_result = r; in_dest = d; in_cond = c;
        {in_carry, in_sign, in_zero} = f; in_flag_we = we;
        out_ready = ordy; flush = fl;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_flags"}, flags_q, 0);
        chk({tag, "_result"}, out_result, 0);
        chk({tag, "_dest"}, out_dest, 0);
        chk({tag, "_taken"}, out_taken, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{3'b000, 3'd0, 1'b1};
        tbl[1]  = '{3'b000, 3'd1, 1'b0};
        tbl[2]  = '{3'b001, 3'd1, 1'b1};
        tbl[3]  = '{3'b001, 3'd2, 1'b0};
        tbl[4]  = '{3'b000, 3'd2, 1'b1};
        tbl[5]  = '{3'b100, 3'd3, 1'b1};
        tbl[6]  = '{3'b011, 3'd3, 1'b0};
        tbl[7]  = '{3'b100, 3'd4, 1'b0};
        tbl[8]  = '{3'b011, 3'd4, 1'b1};
        tbl[9]  = '{3'b010, 3'd5, 1'b1};
        tbl[10] = '{3'b101, 3'd5, 1'b0};
        tbl[11] = '{3'b010, 3'd6, 1'b0};
        tbl[12] = '{3'b101, 3'd6, 1'b1};
        tbl[13] = '{3'b111, 3'd7, 1'b0};
        tbl[14] = '{3'b111, 3'd0, 1'b1};
        tbl[15] = '{3'b110, 3'd1, 1'b0};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Condition table: push with its own flags, check taken and flags, pop
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(1, 32'(i), 5'(i), tbl[i].cond, tbl[i].flags, 1, 0, 0);
            @(negedge clk);
            chk("tbl_out_valid", out_valid, 1);
            chk($sformatf("tbl%0d_taken", i), out_taken, tbl[i].exp);
            chk($sformatf("tbl%0d_flags", i), flags_q, tbl[i].flags);
            drive(0, 0, 0, 0, 0, 0, 1, 0);
        end
        @(negedge clk);
        chk("tbl_drained", out_valid, 0);

        // Basic push: visible next cycle
        drive(1, 32'h5, 5'd3, 3'd1, 3'b001, 1, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("basic_valid", out_valid, 1);
        chk("basic_result", out_result, 32'h5);
        chk("basic_dest", out_dest, 3);
        chk("basic_taken", out_taken, 1);
        chk("basic_flags", flags_q, 3'b001);
        out_ready = 1;
        @(negedge clk);
        chk("basic_empty", out_valid, 0);

        // Back-pressure: A, B accepted, C stalls, then drained in order
        drive(1, 32'hA, 5'd1, 3'd0, 0, 0, 0, 0);
        chk("bp_ready_a", in_ready, 1);
        @(negedge clk);
        drive(1, 32'hB, 5'd2, 3'd0, 0, 0, 0, 0);
        chk("bp_ready_b", in_ready, 1);
        @(negedge clk);
        drive(1, 32'hC, 5'd3, 3'd0, 0, 0, 0, 0);
        chk("bp_ready_c", in_ready, 0);
        @(negedge clk);
        chk("bp_stall", in_ready, 0);
        chk("bp_head_a", out_result, 32'hA);
        out_ready = 1;
        @(negedge clk);
        chk("bp_head_b", out_result, 32'hB);
        chk("bp_ready_after", in_ready, 1);
        @(negedge clk);
        in_valid = 0;
        chk("bp_head_c", out_result, 32'hC);
        chk("bp_c_dest", out_dest, 3);
        @(negedge clk);
        chk("bp_empty", out_valid, 0);

        // Carry from earlier flag write drives CS/CC of later entries
        drive(1, 32'h10, 0, 3'd0, 3'b100, 1, 1, 0);
        @(negedge clk);
        drive(1, 32'h11, 0, 3'd3, 3'b000, 0, 1, 0);
        @(negedge clk);
        chk("cs_taken", out_taken, 1);
        drive(1, 32'h12, 0, 3'd4, 3'b000, 0, 1, 0);
        @(negedge clk);
        chk("cc_taken", out_taken, 0);
        chk("cc_flags", flags_q, 3'b100);
        in_valid = 0;
        @(negedge clk);

        // Streaming at count 1
        drive(1, 32'h100, 0, 3'd0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("stream%0d_head", i), out_result, 32'h100 + 32'(i));
            chk($sformatf("stream%0d_ready", i), in_ready, 1);
            drive(1, 32'h101 + 32'(i), 0, 3'd0, 0, 0, 1, 0);
        end
        @(negedge clk);
        in_valid = 0;
        chk("stream_last", out_result, 32'h104);
        chk("stream_count1", in_ready, 1);
        @(negedge clk);
        chk("stream_empty", out_valid, 0);
        out_ready = 0;

        // Flush at count 2 with a pending push
        drive(1, 32'h20, 0, 3'd0, 3'b010, 1, 0, 0);
        @(negedge clk);
        drive(1, 32'h21, 0, 3'd0, 3'b000, 0, 0, 0);
        @(negedge clk);
        drive(1, 32'h22, 0, 3'd0, 3'b101, 1, 1, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_ready", in_ready, 1);
        chk("flush_flags", flags_q, 3'b010);
        // Flush at count 1 overriding a flag-writing push
        drive(1, 32'h23, 0, 3'd0, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 32'h24, 0, 3'd0, 3'b111, 1, 1, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush1_valid", out_valid, 0);
        chk("flush1_flags", flags_q, 3'b010);
        // Pointers restart at 0 after flush
        drive(1, 32'h25, 5'd9, 3'd0, 0, 0, 0, 0);
        @(negedge clk);
        in_valid = 0;
        chk("post_flush_head", out_result, 32'h25);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;

        // Asynchronous reset mid-cycle with count 2
        drive(1, 32'h30, 5'd4, 3'd0, 3'b111, 1, 0, 0);
        @(negedge clk);
        drive(1, 32'h31, 5'd5, 3'd0, 3'b000, 0, 0, 0);
        @(negedge clk);
        in_valid = 0;
        chk("arst_pre_full", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 32'h40, 5'd7, 3'd2, 3'b000, 1, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("after_rst_result", out_result, 32'h40);
        chk("after_rst_dest", out_dest, 7);
        chk("after_rst_taken", out_taken, 1);

        // Random traffic against a queue model
        do_reset();
        mq.delete();
        mflags = 3'b000;
        for (int i = 0; i < 600; i++) begin
            logic p, q;
            logic [2:0] f, ef;
            @(negedge clk);
            chk("rnd_in_ready", in_ready, mq.size() < 2);
            chk("rnd_out_valid", out_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("rnd_result", out_result, mq[0].r);
                chk("rnd_dest", out_dest, mq[0].d);
                chk("rnd_taken", out_taken, mq[0].t);
            end
            chk("rnd_flags", flags_q, mflags);
            f = 3'($urandom_range(0, 7));
            drive(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
                  3'($urandom_range(0, 7)), f, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
            p = in_valid && (mq.size() < 2);
            q = out_ready && (mq.size() > 0);
            if (flush) begin
                mq.delete();
            end else begin
                ef = in_flag_we ? f : mflags;
                if (q) void'(mq.pop_front());
                if (p) begin
                    mq.push_back('{in_result, in_dest, ref_taken(in_cond, ef)});
                    if (in_flag_we) mflags = f;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
